func_sweeper: RTL and testbench
===============================

# func_sweeper

Sequential test-driver stage that sits directly upstream of a 3-input combinational function block and consumes its output. On `start` it steps the function inputs `{a,b,c}` through all 8 combinations 000→111, waits a programmable settle time per vector, and samples `y` into an 8-bit truth table. It then flags whether the captured table equals a golden value. This gives on-chip self-check of small combinational blocks without a simulator bench.

## Interface
Parameters:
- `SETTLE_CYCLES`, default 1: cycles `{a,b,c}` is held before the SAMPLE cycle. Legal range 1–255; 0 is illegal and a compile-time assertion catches it.
- `EXPECTED`, default 8'h31: golden truth table. Bit index = `{a,b,c}` as an unsigned 3-bit number.

Ports:
- `clk`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start`  in  1  begin a sweep. Sampled only in IDLE.
- `a`, `b`, `c`  out  1 each  registered drive to the function under test. `a` is the MSB of the index.
- `y`  in  1  function output. Sampled only at the edge that leaves SAMPLE.
- `busy`  out  1  high in SETTLE and SAMPLE.
- `done`  out  1  one-cycle pulse when the sweep completes.
- `truth_table`  out  8  captured table. Bit k = `y` observed for index k.
- `match`  out  1  `truth_table == EXPECTED`. Valid from `done` until the next accepted `start`.

## Operation
- States: IDLE, SETTLE, SAMPLE, DONE.
- Registers: `idx[2:0]`, settle counter `cnt[7:0]`, `truth_table[7:0]`, `match`.
- `{a,b,c}` is always driven from `idx`.
- IDLE:
  - On `start`=1: `idx`←0, `cnt`←SETTLE_CYCLES−1, `truth_table`←0, `match`←0, go to SETTLE.
  - Otherwise stay in IDLE.
- SETTLE:
  - If `cnt`==0, go to SAMPLE.
  - Otherwise `cnt`←`cnt`−1.
- SAMPLE:
  - `truth_table[idx]`←`y`.
  - If `idx`==7: `idx`←0, `match`←({`y`,`truth_table[6:0]`}==EXPECTED), go to DONE.
  - Otherwise: `idx`←`idx`+1, `cnt`←SETTLE_CYCLES−1, go to SETTLE.
- DONE: `done`=1 (decoded from state), then go to IDLE unconditionally.
- `start` outside IDLE is ignored, including `start` held high through a sweep. `start` still high on return to IDLE starts a new sweep.
- `idx` never wraps mid-sweep; the 7→0 transition happens only on the SAMPLE→DONE path.
- `truth_table` and `match` hold their values in IDLE until the next accepted `start`.

## Timing
- Reset values: state IDLE, `a`=`b`=`c`=0, `busy`=0, `done`=0, `truth_table`=8'h00, `match`=0, `cnt`=0, `idx`=0.
- Reset asserted mid-sweep aborts immediately and asynchronously to the values above. No `done` pulse is produced.
- Let E0 be the edge that accepts `start`, and S = SETTLE_CYCLES:
  - Vector k is driven from edge E0+k(S+1).
  - Vector k is held S+1 cycles.
  - `y` for vector k is sampled at edge E0+(k+1)(S+1).
- `done` is high for exactly one cycle, after edge E0+8(S+1). With S=1 that is edge E0+16.
- `busy` is high from E0 to E0+8(S+1).
- The earliest re-start is accepted 8(S+1)+2 edges after the previous E0.
- `match` and `truth_table` are already final during the `done` cycle.

## Structure
- Shared package `func_sweep_pkg` contains:
  - `typedef enum logic [1:0] {IDLE, SETTLE, SAMPLE, DONE} sweep_state_t`
  - `localparam VEC_COUNT = 8`
  - `localparam IDX_W = 3`
- Sub-module `settle_timer` (one instance):
  - Inputs: `load`, `load_val[7:0]`.
  - Output: `zero`.
  - Counts down when nonzero.
  - Same `clk` and async `reset`.
- The FSM, `idx`, and capture logic live in `func_sweeper`.

## Test plan
- **Reset mid-sweep:** reset pulse at cycle 5 of a sweep → all outputs return to reset values within the same cycle; no `done` pulse; a new `start` behaves normally.
- **Golden function:** drive `y` = (~a&~b&~c)|(a&~b) with S=1 → `done` at E0+16, `truth_table`=8'h31, `match`=1.
- **Wrong function:** `y`=a^b^c → `truth_table`=8'h96, `match`=0.
- **Per-vector timing, S=3:** check `{a,b,c}` sequence 0,1,…,7, each held exactly 4 cycles; `busy` high for 32 cycles; `done` at E0+32.
- **Start handling:**
  - `start` pulsed during SETTLE of vector 2 → ignored; sweep unchanged.
  - `start` held high continuously → back-to-back sweeps with E0 spacing of 18 cycles at S=1; `truth_table` clears to 0 at each new E0.
- **Settle sensitivity:** `y` model with 1-cycle delay, S=1 → capture still correct (8'h31). Model delay 2, S=1 → mismatch detected (`match`=0).

Source files
------------

// File: rtl/func_sweep_pkg.sv
// Shared types and sizes for the combinational-function sweeper.
// Index width, vector count and settle-counter width are fixed here.
package func_sweep_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETTLE = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } sweep_state_t;

    localparam int VEC_COUNT = 8;
    localparam int IDX_W     = 3;
    localparam int CNT_W     = 8;

endpackage

// File: rtl/settle_timer.sv
// Down-counter holding each test vector for a fixed settle time.
// It reloads on load and otherwise counts down to zero, where it stops.
module settle_timer
    import func_sweep_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    output logic             zero
);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // next count: reload wins, otherwise decrement until zero
    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = load_val;
        end else if (cnt_q != {CNT_W{1'b0}}) begin
            cnt_d = cnt_q - {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            cnt_d = cnt_q;
        end
    end

    // counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign zero = (cnt_q == {CNT_W{1'b0}});

endmodule

// File: rtl/func_sweeper.sv
// Drives {a,b,c} through all 8 input vectors, captures y per vector into a
// truth table and compares the finished table against a golden value.
module func_sweeper
    import func_sweep_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 1,
    parameter logic [7:0]  EXPECTED      = 8'h31
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    output logic       a,
    output logic       b,
    output logic       c,
    input  logic       y,
    output logic       busy,
    output logic       done,
    output logic [7:0] truth_table,
    output logic       match
);

    if ((SETTLE_CYCLES < 32'd1) || (SETTLE_CYCLES > 32'd255)) begin : g_bad_settle
        $error("func_sweeper: SETTLE_CYCLES must be in 1..255");
    end

    localparam logic [CNT_W-1:0] RELOAD   = CNT_W'(SETTLE_CYCLES - 32'd1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(VEC_COUNT - 1);
    localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

    sweep_state_t           state_q, state_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    logic [VEC_COUNT-1:0]   tt_q, tt_d;
    logic                   match_q, match_d;
    logic                   load_s;
    logic                   zero_s;

    settle_timer u_settle_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (load_s),
        .load_val (RELOAD),
        .zero     (zero_s)
    );

    // sweep sequencing, vector stepping and capture
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        tt_d    = tt_q;
        match_d = match_q;
        load_s  = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    idx_d   = {IDX_W{1'b0}};
                    tt_d    = {VEC_COUNT{1'b0}};
                    match_d = 1'b0;
                    load_s  = 1'b1;
                    state_d = SETTLE;
                end else begin
                    state_d = IDLE;
                end
            end
            SETTLE: begin
                if (zero_s) begin
                    state_d = SAMPLE;
                end else begin
                    state_d = SETTLE;
                end
            end
            SAMPLE: begin
                tt_d[idx_q] = y;
                // the final vector's bit is not yet in tt_q, so compare with y spliced in
                if (idx_q == LAST_IDX) begin
                    idx_d   = {IDX_W{1'b0}};
                    match_d = ({y, tt_q[VEC_COUNT-2:0]} == EXPECTED);
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + IDX_ONE;
                    load_s  = 1'b1;
                    state_d = SETTLE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // state, index and result registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            idx_q   <= {IDX_W{1'b0}};
            tt_q    <= {VEC_COUNT{1'b0}};
            match_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            tt_q    <= tt_d;
            match_q <= match_d;
        end
    end

    assign {a, b, c}   = idx_q;
    assign busy        = (state_q == SETTLE) || (state_q == SAMPLE);
    assign done        = (state_q == DONE);
    assign truth_table = tt_q;
    assign match       = match_q;

endmodule

// File: tb/tb_func_sweeper.sv
// Self-checking bench: two sweepers (settle 1 and 3) drive a table-lookup
// function model with optional input delay; expectations come from timing formulas.
module tb_func_sweeper;

    logic       clk = 1'b0;
    logic       reset;
    logic       start1, start3;
    logic       a1, b1, c1, y1, busy1, done1, match1;
    logic       a3, b3, c3, y3, busy3, done3, match3;
    logic [7:0] tt1, tt3;

    logic [7:0] tbl1 = 8'h00, tbl3 = 8'h00;
    int         dly1 = 0, dly3 = 0;
    logic [2:0] h1_1 = 3'd0, h2_1 = 3'd0, h1_3 = 3'd0, h2_3 = 3'd0;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    func_sweeper #(.SETTLE_CYCLES(1), .EXPECTED(8'h31)) u_s1 (
        .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .c(c1), .y(y1),
        .busy(busy1), .done(done1), .truth_table(tt1), .match(match1)
    );

    func_sweeper #(.SETTLE_CYCLES(3), .EXPECTED(8'h31)) u_s3 (
        .clk(clk), .reset(reset), .start(start3), .a(a3), .b(b3), .c(c3), .y(y3),
        .busy(busy3), .done(done3), .truth_table(tt3), .match(match3)
    );

    // function-under-test model: truth-table lookup of the inputs seen dly cycles ago
    always @(posedge clk) begin
        h1_1 <= {a1, b1, c1};
        h2_1 <= h1_1;
        h1_3 <= {a3, b3, c3};
        h2_3 <= h1_3;
    end

    assign y1 = tbl1[(dly1 == 0) ? {a1, b1, c1} : ((dly1 == 1) ? h1_1 : h2_1)];
    assign y3 = tbl3[(dly3 == 0) ? {a3, b3, c3} : ((dly3 == 1) ? h1_3 : h2_3)];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected capture: y sampled at edge m=(k+1)(S+1) reflects the vector driven
    // during cycle m-1-d; before E0 the inputs sat at vector 0.
    function automatic logic [7:0] model_tt(input logic [7:0] tbl, input int s, input int d);
        logic [7:0] r;
        int         ci;
        int         v;
        r = 8'h00;
        for (int k = 0; k < 8; k++) begin
            ci   = (k + 1) * (s + 1) - 1 - d;
            v    = (ci < 0) ? 0 : ci / (s + 1);
            r[k] = tbl[v];
        end
        return r;
    endfunction

    task automatic check_reset_state(input string tag);
        check({tag, " abc1"},   {29'd0, a1, b1, c1}, 32'd0);
        check({tag, " busy1"},  {31'd0, busy1},      32'd0);
        check({tag, " done1"},  {31'd0, done1},      32'd0);
        check({tag, " tt1"},    {24'd0, tt1},        32'd0);
        check({tag, " match1"}, {31'd0, match1},     32'd0);
        check({tag, " abc3"},   {29'd0, a3, b3, c3}, 32'd0);
        check({tag, " busy3"},  {31'd0, busy3},      32'd0);
        check({tag, " tt3"},    {24'd0, tt3},        32'd0);
    endtask

    // One sweep on the selected sweeper. Called at a negedge with it idle;
    // start is raised here so the following posedge is E0.
    task automatic sweep(input int sel, input logic [7:0] tbl, input int d,
                         input bit hold, input int pulse_t, input string name);
        int         s;
        int         last;
        logic [7:0] exp_tt;
        logic       exp_match;
        logic [2:0] o_abc;
        logic       o_busy, o_done, o_match;
        logic [7:0] o_tt;
        logic       st;
        s         = (sel == 3) ? 3 : 1;
        last      = 8 * (s + 1);
        exp_tt    = model_tt(tbl, s, d);
        exp_match = (exp_tt == 8'h31);
        if (sel == 3) begin tbl3 = tbl; dly3 = d; start3 = 1'b1; end
        else          begin tbl1 = tbl; dly1 = d; start1 = 1'b1; end
        @(posedge clk);
        for (int t = 0; t <= last + 1; t++) begin
            @(negedge clk);
            o_abc   = (sel == 3) ? {a3, b3, c3} : {a1, b1, c1};
            o_busy  = (sel == 3) ? busy3  : busy1;
            o_done  = (sel == 3) ? done3  : done1;
            o_tt    = (sel == 3) ? tt3    : tt1;
            o_match = (sel == 3) ? match3 : match1;
            check($sformatf("%s t=%0d abc", name, t), {29'd0, o_abc},
                  (t < last) ? 32'(t / (s + 1)) : 32'd0);
            check($sformatf("%s t=%0d busy", name, t), {31'd0, o_busy}, (t < last) ? 32'd1 : 32'd0);
            check($sformatf("%s t=%0d done", name, t), {31'd0, o_done}, (t == last) ? 32'd1 : 32'd0);
            if (t == 0) begin
                check($sformatf("%s clear tt", name), {24'd0, o_tt}, 32'd0);
                check($sformatf("%s clear match", name), {31'd0, o_match}, 32'd0);
            end
            if (t >= last) begin
                check($sformatf("%s t=%0d tt", name, t), {24'd0, o_tt}, {24'd0, exp_tt});
                check($sformatf("%s t=%0d match", name, t), {31'd0, o_match}, {31'd0, exp_match});
            end
            st = hold || (t == pulse_t);
            if (sel == 3) start3 = st; else start1 = st;
        end
    endtask

    initial begin
        logic [7:0] rt;
        int         rs;
        reset  = 1'b1;
        start1 = 1'b0;
        start3 = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_state("reset");
        reset = 1'b0;
        @(negedge clk);

        sweep(1, 8'h31, 0, 1'b0, -1, "golden");
        sweep(1, 8'h96, 0, 1'b0, -1, "parity");
        sweep(3, 8'h31, 0, 1'b0, -1, "s3_golden");
        sweep(3, 8'($urandom), 0, 1'b0, -1, "s3_rand");
        sweep(1, 8'h31, 0, 1'b0, 4, "start_pulse");

        // start held continuously: each call re-accepts 18 edges after the last E0
        sweep(1, 8'($urandom), 0, 1'b1, -1, "hold_a");
        sweep(1, 8'h96, 0, 1'b1, -1, "hold_b");
        sweep(1, 8'h31, 0, 1'b0, -1, "hold_c");

        sweep(1, 8'h31, 1, 1'b0, -1, "delay1");
        sweep(1, 8'h31, 2, 1'b0, -1, "delay2");

        for (int i = 0; i < 4; i++) begin
            rt = 8'($urandom);
            rs = ($urandom_range(0, 1) == 0) ? 1 : 3;
            sweep(rs, rt, int'($urandom_range(0, 1)), 1'b0, -1, $sformatf("rand%0d", i));
        end

        // reset pulse five cycles into a sweep aborts asynchronously
        tbl1 = 8'h31;
        dly1 = 0;
        start1 = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start1 = 1'b0;
        repeat (4) @(negedge clk);
        #2 reset = 1'b1;
        #1 check_reset_state("midreset");
        @(negedge clk);
        reset = 1'b0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            check($sformatf("post_reset t=%0d done", t), {31'd0, done1}, 32'd0);
        end
        sweep(1, 8'h31, 0, 1'b0, -1, "after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
